// File: rtl/lr_feature_framer_pkg.sv
// Shared constants, FSM state type and helpers for the linear-regression feature framer.
package lr_feature_framer_pkg;

  localparam int unsigned FP_W       = 32;
  localparam int unsigned NUM_FEAT   = 5;
  localparam int unsigned FP_EXP_MSB = 30;
  localparam int unsigned FP_EXP_LSB = 23;
  localparam int unsigned IDX_W      = 3;

  typedef enum logic [1:0] {
    StCollect,
    StDrain,
    StSettle,
    StHold
  } state_e;

  // All-ones exponent covers both Inf and NaN.
  function automatic logic is_nonfinite(input logic [FP_W-1:0] w);
    return &w[FP_EXP_MSB:FP_EXP_LSB];
  endfunction

endpackage

// File: rtl/lr_feature_framer_bank.sv
// Feature register bank: holds the x1..x5 words presented to the regressor.
module lr_feature_framer_bank
  import lr_feature_framer_pkg::*;
#(
  parameter int unsigned DATA_W = FP_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [IDX_W-1:0]                 idx,
  input  logic [DATA_W-1:0]                data,
  output logic [NUM_FEAT-1:0][DATA_W-1:0]  feat
);

  always_ff @(posedge clk) begin
    if (rst) begin
      feat <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_FEAT; i++) begin
        if (idx == IDX_W'(i)) feat[i] <= data;
      end
    end
  end

endmodule

// File: rtl/lr_feature_framer.sv
// Frames 5 streamed FP words into stable regressor inputs, waits a settle time,
// then captures the regressor result and hands it downstream.
module lr_feature_framer
  import lr_feature_framer_pkg::*;
#(
  parameter int unsigned DATA_W        = FP_W,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [DATA_W-1:0] feat_x1,
  output logic [DATA_W-1:0] feat_x2,
  output logic [DATA_W-1:0] feat_x3,
  output logic [DATA_W-1:0] feat_x4,
  output logic [DATA_W-1:0] feat_x5,
  input  logic [DATA_W-1:0] lr_y,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_nonfinite,
  output logic              err_short,
  output logic              err_long,
  output logic [CNT_W-1:0]  frames_done
);

  localparam int unsigned SET_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SET_LAST  = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam state_e      StAfter   = (SETTLE_CYCLES == 0) ? StHold : StSettle;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SET_W-1:0]   cnt_q, cnt_d;
  logic               nf_acc_q, nf_acc_d;
  logic [DATA_W-1:0]  m_data_q;
  logic               m_nf_q;
  logic               err_short_q, err_short_d;
  logic               err_long_q, err_long_d;
  logic [CNT_W-1:0]   frames_q;
  logic               accept, bank_we, capture, handoff, last_idx;
  logic [NUM_FEAT-1:0][DATA_W-1:0] feat;

  assign accept   = s_valid && s_ready;
  assign last_idx = (idx_q == IDX_W'(NUM_FEAT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StCollect;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    nf_acc_d    = nf_acc_q;
    bank_we     = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    capture     = 1'b0;
    handoff     = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (accept) begin
          bank_we  = 1'b1;
          nf_acc_d = nf_acc_q | is_nonfinite(s_data);
          if (!last_idx) begin
            if (s_last) begin
              err_short_d = 1'b1;
              idx_d       = '0;
              nf_acc_d    = 1'b0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else if (s_last) begin
            state_d = StAfter;
            cnt_d   = '0;
          end else begin
            err_long_d = 1'b1;
            state_d    = StDrain;
          end
        end
      end
      StDrain: begin
        if (accept && s_last) begin
          state_d = StAfter;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        if (cnt_q == SET_W'(SET_LAST)) begin
          capture = 1'b1;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (m_ready) begin
          handoff  = 1'b1;
          state_d  = StCollect;
          idx_d    = '0;
          nf_acc_d = 1'b0;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_comb begin
    s_ready = (state_q == StCollect) || (state_q == StDrain);
    m_valid = (state_q == StHold);
    m_data  = m_data_q;
    // With no settle time y is only valid once HOLD is entered; features are frozen there.
    if ((SETTLE_CYCLES == 0) && (state_q == StHold)) m_data = lr_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      nf_acc_q    <= 1'b0;
      m_data_q    <= '0;
      m_nf_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      frames_q    <= '0;
    end else begin
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      nf_acc_q    <= nf_acc_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      if (capture || (handoff && (SETTLE_CYCLES == 0))) m_data_q <= lr_y;
      if ((state_q != StHold) && (state_d == StHold)) m_nf_q <= nf_acc_d;
      if (handoff) frames_q <= frames_q + 1'b1;
    end
  end

  lr_feature_framer_bank #(
    .DATA_W (DATA_W)
  ) u_bank (
    .clk  (clk),
    .rst  (rst),
    .we   (bank_we),
    .idx  (idx_q),
    .data (s_data),
    .feat (feat)
  );

  assign feat_x1     = feat[0];
  assign feat_x2     = feat[1];
  assign feat_x3     = feat[2];
  assign feat_x4     = feat[3];
  assign feat_x5     = feat[4];
  assign m_nonfinite = m_nf_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;
  assign frames_done = frames_q;

endmodule

// File: tb/tb_lr_feature_framer.sv
// Bench for lr_feature_framer: DUT 0 settles 2 cycles, DUT 1 settles 0 cycles with a 4-bit counter.
module tb_lr_feature_framer;

  logic                  clk;
  logic [1:0]            rst, s_valid, s_last, s_ready, m_valid, m_ready, m_nf, err_short, err_long;
  logic [1:0][31:0]      s_data, lr_y, m_data;
  logic [1:0][4:0][31:0] feat;
  logic [15:0]           frames_a;
  logic [3:0]            frames_b;

  int n_checks = 0;
  int n_pass = 0;
  int exp_frames[2] = '{0, 0};
  int short_seen[2] = '{0, 0};
  int long_seen[2] = '{0, 0};
  int both_seen = 0;

  // Stand-in for the regressor: any bit-sensitive function of all five inputs.
  function automatic logic [31:0] y_fn(input logic [31:0] x1, x2, x3, x4, x5);
    return x1 ^ {x2[15:0], x2[31:16]} ^ (x3 + x4) ^ ~x5;
  endfunction

  assign lr_y[0] = y_fn(feat[0][0], feat[0][1], feat[0][2], feat[0][3], feat[0][4]);
  assign lr_y[1] = y_fn(feat[1][0], feat[1][1], feat[1][2], feat[1][3], feat[1][4]);

  lr_feature_framer #(.DATA_W(32), .SETTLE_CYCLES(2), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
    .s_last(s_last[0]), .feat_x1(feat[0][0]), .feat_x2(feat[0][1]), .feat_x3(feat[0][2]),
    .feat_x4(feat[0][3]), .feat_x5(feat[0][4]), .lr_y(lr_y[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready[0]), .m_data(m_data[0]), .m_nonfinite(m_nf[0]), .err_short(err_short[0]),
    .err_long(err_long[0]), .frames_done(frames_a)
  );

  lr_feature_framer #(.DATA_W(32), .SETTLE_CYCLES(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
    .s_last(s_last[1]), .feat_x1(feat[1][0]), .feat_x2(feat[1][1]), .feat_x3(feat[1][2]),
    .feat_x4(feat[1][3]), .feat_x5(feat[1][4]), .lr_y(lr_y[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready[1]), .m_data(m_data[1]), .m_nonfinite(m_nf[1]), .err_short(err_short[1]),
    .err_long(err_long[1]), .frames_done(frames_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (err_short[s] === 1'b1) short_seen[s]++;
      if (err_long[s] === 1'b1) long_seen[s]++;
      if (err_short[s] === 1'b1 && err_long[s] === 1'b1) both_seen++;
    end
  end

  function automatic logic [15:0] frames_of(input bit sel);
    return sel ? {12'b0, frames_b} : frames_a;
  endfunction

  function automatic logic [15:0] frames_want(input bit sel);
    return sel ? 16'(exp_frames[1] % 16) : 16'(exp_frames[0] % 65536);
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (&w[30:23]) w[23] = 1'b0;
    return w;
  endfunction

  function automatic bit nf_of(input logic [31:0] w[8], input int last_at);
    bit nf = 0;
    for (int i = 0; i <= last_at && i < 5; i++) if (w[i][30:23] == 8'hFF) nf = 1;
    return nf;
  endfunction

  // Drives words 0..last_at with random gaps; checks error pulses the cycle after word 5 / s_last.
  task automatic send_words(input bit sel, input logic [31:0] w[8], input int last_at,
                            input string name);
    for (int i = 0; i <= last_at; i++) begin
      int g = 0;
      while (s_ready[sel] !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      n_checks++;
      if (s_ready[sel] !== 1'b1) $display("FAIL %s s_ready word%0d got %b want 1", name, i, s_ready[sel]);
      else n_pass++;
      s_valid[sel] = 1'b1; s_data[sel] = w[i]; s_last[sel] = (i == last_at);
      @(negedge clk);
      s_valid[sel] = 1'b0; s_last[sel] = 1'b0;
      if (i == 4 || i == last_at) begin
        logic [1:0] want;
        want = {(i == last_at && i < 4), (i == 4 && last_at > 4)};
        n_checks++;
        if ({err_short[sel], err_long[sel]} !== want)
          $display("FAIL %s err{short,long} word%0d got %b want %b", name, i,
                   {err_short[sel], err_long[sel]}, want);
        else n_pass++;
      end
      if (i != last_at) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Called right after the last accepted word: checks latency, result, stability and handoff.
  task automatic expect_result(input bit sel, input logic [31:0] w[8], input bit exp_nf,
                               input int hold, input string name);
    logic [31:0] exp_y;
    int lat = 1;
    exp_y = y_fn(w[0], w[1], w[2], w[3], w[4]);
    while (m_valid[sel] !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat != (sel ? 1 : 3)) $display("FAIL %s latency got %0d want %0d", name, lat, sel ? 1 : 3);
    else n_pass++;
    n_checks++;
    if (m_data[sel] !== exp_y) $display("FAIL %s m_data got %h want %h", name, m_data[sel], exp_y);
    else n_pass++;
    n_checks++;
    if (m_nf[sel] !== exp_nf) $display("FAIL %s m_nonfinite got %b want %b", name, m_nf[sel], exp_nf);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (feat[sel][k] !== w[k]) $display("FAIL %s feat_x%0d got %h want %h", name, k + 1, feat[sel][k], w[k]);
      else n_pass++;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      n_checks++;
      if ({m_valid[sel], s_ready[sel], m_data[sel], m_nf[sel]} !== {2'b10, exp_y, exp_nf})
        $display("FAIL %s hold%0d {valid,ready,data,nf} got %b %b %h %b want 1 0 %h %b", name, k,
                 m_valid[sel], s_ready[sel], m_data[sel], m_nf[sel], exp_y, exp_nf);
      else n_pass++;
    end
    m_ready[sel] = 1'b1;
    @(negedge clk);
    m_ready[sel] = 1'b0;
    exp_frames[sel]++;
    n_checks++;
    if (m_valid[sel] !== 1'b0) $display("FAIL %s m_valid after handoff got %b want 0", name, m_valid[sel]);
    else n_pass++;
    n_checks++;
    if (frames_of(sel) !== frames_want(sel))
      $display("FAIL %s frames_done got %h want %h", name, frames_of(sel), frames_want(sel));
    else n_pass++;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if ({m_valid[s], m_data[s], m_nf[s], err_short[s], err_long[s], frames_of(s[0]), feat[s]} !== '0)
        $display("FAIL reset dut%0d outputs got v=%b d=%h nf=%b es=%b el=%b fd=%h want all 0", s,
                 m_valid[s], m_data[s], m_nf[s], err_short[s], err_long[s], frames_of(s[0]));
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    logic [31:0] w[8];
    for (int i = 0; i < 8; i++) w[i] = 32'h3F80_0000;
    m_ready[0] = 1'b1;
    send_words(0, w, 4, "basic");
    expect_result(0, w, 0, 0, "basic");
  endtask

  task automatic test_random_frames();
    logic [31:0] w[8];
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) w[i] = rand_word();
      send_words(0, w, 4, "random");
      expect_result(0, w, 0, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[8];
    for (int i = 0; i < 8; i++) w[i] = rand_word();
    send_words(0, w, 4, "backpressure");
    expect_result(0, w, 0, 10, "backpressure");
  endtask

  task automatic test_short();
    logic [31:0] w[8], w2[8];
    int s0 = short_seen[0];
    bit seen_valid = 0;
    for (int i = 0; i < 8; i++) begin w[i] = rand_word(); w2[i] = rand_word(); end
    w[1] = 32'hFF80_0000;  // non-finite in a discarded frame must not leak into the next one
    send_words(0, w, 2, "short");
    repeat (6) begin @(negedge clk); if (m_valid[0] === 1'b1) seen_valid = 1; end
    n_checks++;
    if (seen_valid) $display("FAIL short spurious m_valid got 1 want 0"); else n_pass++;
    send_words(0, w2, 4, "short_next");
    expect_result(0, w2, 0, 1, "short_next");
    n_checks++;
    if (short_seen[0] - s0 != 1) $display("FAIL short pulse count got %0d want 1", short_seen[0] - s0);
    else n_pass++;
  endtask

  task automatic test_long();
    logic [31:0] w[8];
    int l0 = long_seen[0];
    for (int i = 0; i < 8; i++) w[i] = rand_word();
    w[6] = 32'h7FC0_0001;  // dropped word must not set the non-finite flag
    send_words(0, w, 6, "long");
    expect_result(0, w, 0, 0, "long");
    n_checks++;
    if (long_seen[0] - l0 != 1) $display("FAIL long pulse count got %0d want 1", long_seen[0] - l0);
    else n_pass++;
  endtask

  task automatic test_nonfinite();
    logic [31:0] w[8];
    for (int i = 0; i < 8; i++) w[i] = rand_word();
    w[1] = 32'h7F80_0000;
    send_words(0, w, 4, "nonfinite");
    expect_result(0, w, nf_of(w, 4), 0, "nonfinite");
    for (int i = 0; i < 8; i++) w[i] = rand_word();
    send_words(0, w, 4, "clean_after_nf");
    expect_result(0, w, nf_of(w, 4), 0, "clean_after_nf");
  endtask

  task automatic test_reset_mid();
    logic [31:0] w[8];
    bit seen_valid = 0;
    for (int i = 0; i < 8; i++) w[i] = rand_word();
    send_words(0, w, 4, "rst_mid");
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    exp_frames[0] = 0;
    repeat (6) begin if (m_valid[0] === 1'b1) seen_valid = 1; @(negedge clk); end
    n_checks++;
    if (seen_valid) $display("FAIL rst_mid stale m_valid got 1 want 0"); else n_pass++;
    n_checks++;
    if ({frames_a, feat[0][0]} !== '0)
      $display("FAIL rst_mid frames/feat got %h %h want 0 0", frames_a, feat[0][0]);
    else n_pass++;
    for (int i = 0; i < 8; i++) w[i] = rand_word();
    send_words(0, w, 4, "rst_fresh");
    expect_result(0, w, 0, 2, "rst_fresh");
  endtask

  task automatic test_settle0_wrap();
    logic [31:0] w[8];
    for (int f = 0; f < 18; f++) begin
      for (int i = 0; i < 8; i++) w[i] = rand_word();
      if (f == 3) w[4] = 32'hFFFF_FFFF;
      send_words(1, w, (f == 5) ? 5 : 4, "settle0");
      expect_result(1, w, nf_of(w, 4), f % 2, "settle0");
    end
  endtask

  initial begin
    rst = 2'b11; s_valid = '0; s_last = '0; s_data = '0; m_ready = '0;
    repeat (3) @(negedge clk);
    rst = 2'b00;
    test_reset();
    test_basic();
    test_random_frames();
    test_backpressure();
    test_short();
    test_long();
    test_nonfinite();
    test_reset_mid();
    test_settle0_wrap();
    @(negedge clk);
    n_checks++;
    if ({both_seen, short_seen[0], long_seen[0], short_seen[1], long_seen[1]} !== {32'd0, 32'd1, 32'd1, 32'd0, 32'd1})
      $display("FAIL err_totals got both=%0d a_s=%0d a_l=%0d b_s=%0d b_l=%0d want 0 1 1 0 1",
               both_seen, short_seen[0], long_seen[0], short_seen[1], long_seen[1]);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "timeout");
  end

endmodule
